// File: rtl/control_sequencer.sv
// Moore control unit: fetch/decode/execute strobes for the load/store/ALU/branch ISA.
// Latency: outputs decode the present state; one state per Clock; 3-8 cycles per instruction.
// Backpressure: Stop requests a pause that is taken only at instruction boundaries; HALT exits only via Clear.
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        CONin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  ALU_op,
    output logic        Run
);
    localparam logic [3:0] S_RESET = 4'd0,  S_F0 = 4'd1, S_F1 = 4'd2, S_F2 = 4'd3,
                           S_T3    = 4'd4,  S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7,
                           S_T7    = 4'd8,  S_PAUSE = 4'd9, S_HALT = 4'd10;

    localparam logic [4:0] OP_LD  = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                           OP_ADD = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                           OP_OR  = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101,
                           OP_ORI = 5'b01110, OP_BR   = 5'b10010, OP_JR   = 5'b10100,
                           OP_HALT = 5'b11001;

    logic [3:0] state, state_nxt;
    logic [4:0] opc;
    logic       is_alu, is_imm, is_ldi, is_ld, is_st, is_br, is_jr, is_halt, is_nop;
    logic       at_boundary;
    logic [3:0] boundary_nxt;
    logic       ir_unused;

    assign opc       = IR[31:27];
    assign ir_unused = ^IR[26:0];

    assign is_alu  = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    assign is_imm  = (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI);
    assign is_ldi  = (opc == OP_LDI);
    assign is_ld   = (opc == OP_LD);
    assign is_st   = (opc == OP_ST);
    assign is_br   = (opc == OP_BR);
    assign is_jr   = (opc == OP_JR);
    assign is_halt = (opc == OP_HALT);
    // Unassigned opcodes fall through to nop behaviour.
    assign is_nop  = !(is_alu || is_imm || is_ldi || is_ld || is_st || is_br || is_jr || is_halt);

    always_comb begin
        at_boundary = 1'b0;
        case (state)
            S_F2:    at_boundary = is_nop;
            S_T3:    at_boundary = is_jr;
            S_T5:    at_boundary = is_alu || is_imm || is_ldi;
            S_T6:    at_boundary = is_br;
            S_T7:    at_boundary = 1'b1;
            default: at_boundary = 1'b0;
        endcase
    end

    assign boundary_nxt = Stop ? S_PAUSE : S_F0;

    always_comb begin
        state_nxt = S_RESET;
        case (state)
            S_RESET: state_nxt = S_F0;
            S_F0:    state_nxt = S_F1;
            S_F1:    state_nxt = S_F2;
            S_F2:    state_nxt = is_halt ? S_HALT : (at_boundary ? boundary_nxt : S_T3);
            S_T3, S_T4, S_T5, S_T6, S_T7:
                     state_nxt = at_boundary ? boundary_nxt : state + 4'd1;
            S_PAUSE: state_nxt = Stop ? S_PAUSE : S_F0;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= S_RESET;
        else        state <= state_nxt;
    end

    always_comb begin
        {PCout, Zhighout, Zlowout, MDRout, Cout, BAout} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, CONin}     = '0;
        {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout}  = '0;
        ALU_op = 5'b00000;
        Run    = !(state == S_RESET || state == S_PAUSE || state == S_HALT);
        case (state)
            S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_F1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_F2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_br || is_jr) begin
                    Gra = 1'b1; Rout = 1'b1;
                    CONin = is_br; PCin = is_jr;
                end else if (is_alu || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end
            end
            S_T4: begin
                if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else begin
                    Zin  = 1'b1;
                    Grc  = is_alu; Rout = is_alu;
                    Cout = !is_alu;
                    if (is_alu)                 ALU_op = opc;
                    else if (opc == OP_ANDI)    ALU_op = 5'b00101;
                    else if (opc == OP_ORI)     ALU_op = 5'b00110;
                    else                        ALU_op = 5'b00011;
                end
            end
            S_T5: begin
                if (is_br) begin
                    Cout = 1'b1; Zin = 1'b1; ALU_op = 5'b00011;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T6: begin
                if (is_br) begin
                    Zlowout = 1'b1; PCin = CON_FF;
                end else if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: each task drives one scenario and checks every cycle.
module tb_control_sequencer;
    logic        Clock = 1'b0;
    logic        Clear, CON_FF, Stop;
    logic [31:0] IR;
    logic PCout, Zhighout, Zlowout, MDRout, Cout, BAout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, CONin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout;
    logic [4:0] ALU_op;
    logic Run;

    int errors = 0;
    int checks = 0;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .Cout(Cout), .BAout(BAout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .CONin(CONin), .IncPC(IncPC),
        .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .ALU_op(ALU_op), .Run(Run)
    );

    always #5 Clock = ~Clock;

    // Strobe bit masks, MSB first: PCout .. Rout.
    localparam logic [20:0] M_PCOUT = 21'd1 << 20, M_ZHIGH = 21'd1 << 19, M_ZLOW  = 21'd1 << 18,
                            M_MDROUT = 21'd1 << 17, M_COUT = 21'd1 << 16, M_BAOUT = 21'd1 << 15,
                            M_MARIN = 21'd1 << 14, M_ZIN   = 21'd1 << 13, M_PCIN  = 21'd1 << 12,
                            M_MDRIN = 21'd1 << 11, M_IRIN  = 21'd1 << 10, M_YIN   = 21'd1 << 9,
                            M_CONIN = 21'd1 << 8,  M_INCPC = 21'd1 << 7,  M_READ  = 21'd1 << 6,
                            M_WRITE = 21'd1 << 5,  M_GRA   = 21'd1 << 4,  M_GRB   = 21'd1 << 3,
                            M_GRC   = 21'd1 << 2,  M_RIN   = 21'd1 << 1,  M_ROUT  = 21'd1 << 0;

    localparam logic [26:0] IDLE = 27'd0;
    localparam logic [26:0] F0 = {M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b00000, 1'b1};
    localparam logic [26:0] F1 = {M_ZLOW | M_PCIN | M_READ | M_MDRIN,  5'b00000, 1'b1};
    localparam logic [26:0] F2 = {M_MDROUT | M_IRIN,                   5'b00000, 1'b1};

    function automatic logic [26:0] ex(input logic [20:0] m, input logic [4:0] a);
        return {m, a, 1'b1};
    endfunction

    function automatic logic [26:0] obs();
        return {PCout, Zhighout, Zlowout, MDRout, Cout, BAout, MARin, Zin, PCin, MDRin,
                IRin, Yin, CONin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, ALU_op, Run};
    endfunction

    task automatic pulse_clear();
        @(negedge Clock);
        Clear = 1'b0;
        #2;
        Clear = 1'b1;
    endtask

    task automatic test_reset();
        logic [26:0] o;
        Clear = 1'b0; Stop = 1'b0; CON_FF = 1'b0; IR = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            o = obs(); checks++;
            if (o !== IDLE) begin
                $display("FAIL reset_hold cyc %0d: got %h want %h", i, o, IDLE); errors++;
            end
        end
        @(negedge Clock); Clear = 1'b1;
        @(posedge Clock); #1;
        o = obs(); checks++;
        if (o !== F0) begin $display("FAIL reset_exit: got %h want %h", o, F0); errors++; end
    endtask

    task automatic test_add();
        logic [26:0] e [7];
        logic [26:0] o;
        e = '{F0, F1, F2, ex(M_GRB | M_ROUT | M_YIN, 5'b0), ex(M_GRC | M_ROUT | M_ZIN, 5'b00011),
              ex(M_ZLOW | M_GRA | M_RIN, 5'b0), F0};
        IR = 32'h18C00000;
        pulse_clear();
        for (int i = 0; i < 7; i++) begin
            @(posedge Clock); #1;
            o = obs(); checks++;
            if (o !== e[i]) begin $display("FAIL add cyc %0d: got %h want %h", i + 1, o, e[i]); errors++; end
        end
    endtask

    task automatic test_br(input logic cond);
        logic [26:0] e [8];
        logic [26:0] o;
        e = '{F0, F1, F2, ex(M_GRA | M_ROUT | M_CONIN, 5'b0), ex(M_PCOUT | M_YIN, 5'b0),
              ex(M_COUT | M_ZIN, 5'b00011), ex(M_ZLOW | (cond ? M_PCIN : 21'd0), 5'b0), F0};
        IR = 32'h91600023;
        CON_FF = cond;
        pulse_clear();
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock); #1;
            o = obs(); checks++;
            if (o !== e[i]) begin
                $display("FAIL br con=%0d cyc %0d: got %h want %h", cond, i + 1, o, e[i]); errors++;
            end
        end
        CON_FF = 1'b0;
    endtask

    task automatic test_ld_st();
        logic [26:0] el [8];
        logic [26:0] es [9];
        logic [26:0] o;
        el = '{F0, F1, F2, ex(M_GRB | M_BAOUT | M_YIN, 5'b0), ex(M_COUT | M_ZIN, 5'b00011),
               ex(M_ZLOW | M_MARIN, 5'b0), ex(M_READ | M_MDRIN, 5'b0), ex(M_MDROUT | M_GRA | M_RIN, 5'b0)};
        es = '{F0, F1, F2, ex(M_GRB | M_BAOUT | M_YIN, 5'b0), ex(M_COUT | M_ZIN, 5'b00011),
               ex(M_ZLOW | M_MARIN, 5'b0), ex(M_GRA | M_ROUT | M_MDRIN, 5'b0), ex(M_WRITE, 5'b0), F0};
        IR = 32'h00800010;
        pulse_clear();
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock); #1;
            o = obs(); checks++;
            if (o !== el[i]) begin $display("FAIL ld cyc %0d: got %h want %h", i + 1, o, el[i]); errors++; end
        end
        IR = 32'h10800010;
        for (int i = 0; i < 9; i++) begin
            @(posedge Clock); #1;
            o = obs(); checks++;
            if (o !== es[i]) begin $display("FAIL st cyc %0d: got %h want %h", i + 1, o, es[i]); errors++; end
        end
    endtask

    task automatic test_short();
        logic [26:0] ej [5];
        logic [26:0] en [4];
        logic [26:0] o;
        ej = '{F0, F1, F2, ex(M_GRA | M_ROUT | M_PCIN, 5'b0), F0};
        en = '{F0, F1, F2, F0};
        IR = 32'hA0000000;
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock); #1;
            o = obs(); checks++;
            if (o !== ej[i]) begin $display("FAIL jr cyc %0d: got %h want %h", i + 1, o, ej[i]); errors++; end
        end
        IR = 32'hC0000000;
        for (int i = 1; i < 4; i++) begin
            @(posedge Clock); #1;
            o = obs(); checks++;
            if (o !== en[i]) begin $display("FAIL nop cyc %0d: got %h want %h", i + 1, o, en[i]); errors++; end
        end
        IR = 32'hF8000000;
        for (int i = 1; i < 4; i++) begin
            @(posedge Clock); #1;
            o = obs(); checks++;
            if (o !== en[i]) begin $display("FAIL undef_op cyc %0d: got %h want %h", i + 1, o, en[i]); errors++; end
        end
    endtask

    task automatic test_clear_mid();
        logic [26:0] o;
        logic [26:0] t5;
        t5 = ex(M_ZLOW | M_MARIN, 5'b0);
        IR = 32'h00800010;
        pulse_clear();
        repeat (6) @(posedge Clock);
        #1;
        o = obs(); checks++;
        if (o !== t5) begin $display("FAIL clr_pre_t5: got %h want %h", o, t5); errors++; end
        #1; Clear = 1'b0; #1;
        o = obs(); checks++;
        if (o !== IDLE) begin $display("FAIL clr_same_cycle: got %h want %h", o, IDLE); errors++; end
        @(posedge Clock); #1;
        o = obs(); checks++;
        if (o !== IDLE) begin $display("FAIL clr_held: got %h want %h", o, IDLE); errors++; end
        @(negedge Clock); Clear = 1'b1;
        @(posedge Clock); #1;
        o = obs(); checks++;
        if (o !== F0) begin $display("FAIL clr_release: got %h want %h", o, F0); errors++; end
    endtask

    task automatic test_stop();
        logic [26:0] o;
        logic [26:0] t5;
        t5 = ex(M_ZLOW | M_GRA | M_RIN, 5'b0);
        IR = 32'h18C00000;
        pulse_clear();
        repeat (5) @(posedge Clock);
        #1;
        Stop = 1'b1;
        @(posedge Clock); #1;
        o = obs(); checks++;
        if (o !== t5) begin $display("FAIL stop_t5: got %h want %h", o, t5); errors++; end
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock); #1;
            o = obs(); checks++;
            if (o !== IDLE) begin $display("FAIL stop_pause %0d: got %h want %h", i, o, IDLE); errors++; end
        end
        Stop = 1'b0;
        @(posedge Clock); #1;
        o = obs(); checks++;
        if (o !== F0) begin $display("FAIL stop_resume: got %h want %h", o, F0); errors++; end
    endtask

    task automatic test_halt();
        logic [26:0] o;
        IR = 32'hC8000000;
        pulse_clear();
        repeat (3) @(posedge Clock);
        #1;
        o = obs(); checks++;
        if (o !== F2) begin $display("FAIL halt_f2: got %h want %h", o, F2); errors++; end
        for (int i = 0; i < 20; i++) begin
            Stop = (i % 2 == 1);
            @(posedge Clock); #1;
            o = obs(); checks++;
            if (o !== IDLE) begin $display("FAIL halt_hold %0d: got %h want %h", i, o, IDLE); errors++; end
        end
        Stop = 1'b0;
        pulse_clear();
        @(posedge Clock); #1;
        o = obs(); checks++;
        if (o !== F0) begin $display("FAIL halt_exit: got %h want %h", o, F0); errors++; end
    endtask

    initial begin
        test_reset();
        test_add();
        test_br(1'b1);
        test_br(1'b0);
        test_ld_st();
        test_short();
        test_clear_mid();
        test_stop();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters: none; opcode map fixed by REQ-013.
REQ-002 Clock  input  1  sole clock; all state changes on rising edge.
REQ-003 Clear  input  1  asynchronous, active-low reset.
REQ-004 IR  input  32  instruction register contents; opcode = IR[31:27].
REQ-005 CON_FF  input  1  branch-condition flip-flop output from the datapath.
REQ-006 Stop  input  1  pause request, sampled only at instruction boundaries.
REQ-007 PCout, Zhighout, Zlowout, MDRout, Cout, BAout  output  1 each  bus-source strobes.
REQ-008 MARin, Zin, PCin, MDRin, IRin, Yin, CONin  output  1 each  register-load strobes.
REQ-009 IncPC, Read, Write  output  1 each  PC-increment and memory strobes.
REQ-010 Gra, Grb, Grc, Rin, Rout  output  1 each  register-file select and enable.
REQ-011 ALU_op  output  5  ALU operation code.
REQ-012 Run  output  1  high while executing; low in RESET, PAUSE, HALT.

Function
REQ-013 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, br 10010, jr 10100, nop 11000, halt 11001; any other opcode executes as nop.
REQ-014 Moore FSM; every output is a decode of present state (and IR/CON_FF where stated), one state per Clock cycle; outputs not listed for a state are 0.
REQ-015 ALU_op = 00000 except in states asserting Zin after fetch: R-type gives opcode, addi/andi/ori give 00011/00101/00110, ld/ldi/st/br give 00011.
REQ-016 RESET -> FETCH0 on first rising edge after Clear deasserted.
REQ-017 FETCH0: PCout, MARin, IncPC, Zin. FETCH1: Zlowout, PCin, Read, MDRin. FETCH2: MDRout, IRin; then dispatch on the opcode then present on IR.
REQ-018 add/sub/and/or: T3 Grb Rout Yin; T4 Grc Rout Zin; T5 Zlowout Gra Rin.
REQ-019 addi/andi/ori: T3 Grb Rout Yin; T4 Cout Zin; T5 Zlowout Gra Rin.
REQ-020 ldi: T3 Grb BAout Yin; T4 Cout Zin; T5 Zlowout Gra Rin.
REQ-021 ld: T3-T4 as ldi; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
REQ-022 st: T3-T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write.
REQ-023 br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin; T6 Zlowout, PCin = CON_FF sampled in T6.
REQ-024 jr: T3 Gra Rout PCin. nop: FETCH2 goes directly to boundary.
REQ-025 halt: FETCH2 -> HALT; HALT holds all strobes 0 and exits only via Clear.
REQ-026 Boundary = last state of any instruction (nop: FETCH2); next state is PAUSE if Stop=1, else FETCH0; Stop in any other state is ignored.
REQ-027 PAUSE: all strobes 0; -> FETCH0 on first edge with Stop=0.
REQ-028 Longest instruction (ld, st) = 8 cycles FETCH0-T7; jr = 4; nop = 3.

Reset
REQ-029 Clear low forces RESET immediately regardless of Clock, mid-instruction included; all outputs 0, ALU_op 00000, Run 0 while Clear is low.
REQ-030 No partial strobe may be emitted on the Clear edge; the aborted instruction is not resumed.

Verification
REQ-031 Clear pulse, then IR=0x18C00000 (add R1,R2,R3) -> FETCH0-T5 strobes per REQ-017/018, ALU_op=00011 in T4, Gra+Rin in cycle 6, FETCH0 in cycle 7.
REQ-032 IR=0x91600023 (br, CON_FF=1 in T6) -> PCin=1 with Zlowout in T6; repeat with CON_FF=0 -> PCin=0 in T6.
REQ-033 ld then st sequences -> Read only in FETCH1 and ld T6; Write only in st T7; 8 cycles each.
REQ-034 Clear low during ld T5 -> all outputs 0 same cycle; after release, FETCH0 strobes one edge later.
REQ-035 Stop=1 during add T4 -> completes T5, enters PAUSE (Run=0); Stop=0 -> FETCH0 next edge.
REQ-036 IR=0xC8000000 (halt) -> HALT after FETCH2, Run=0 for 20 cycles with Stop toggled; only Clear exits.
